// File: rtl/hamming_pkg.sv
// Shared widths, codeword position indices and FSM state types for the Hamming link.
// Defining HAMMING_SECDED_EN widens the codeword with an overall-parity bit at position 8.
package hamming_pkg;
`ifdef HAMMING_SECDED_EN
  localparam int CW_BITS = 8;
`else
  localparam int CW_BITS = 7;
`endif
  localparam int DATA_BITS = 4;
  localparam int SYN_BITS  = 3;
  localparam int CNT_W     = 8;  // holds any BIT_CYCLES / GAP_CYCLES count up to 255
  localparam int BIT_W     = 4;  // holds a bit index up to CW_BITS-1

  // Vector index of each codeword position (index = position - 1).
  localparam int POS_P1   = 0;
  localparam int POS_P2   = 1;
  localparam int POS_D1   = 2;
  localparam int POS_P4   = 3;
  localparam int POS_D2   = 4;
  localparam int POS_D3   = 5;
  localparam int POS_D4   = 6;
  localparam int POS_PALL = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SAMPLE = 2'd1,
    RX_DECODE = 2'd2
  } rx_state_e;
endpackage

// File: rtl/hamming74_codec.sv
// Combinational (7,4) Hamming encoder and single-error-correcting decoder.
// With HAMMING_SECDED_EN the overall parity bit adds double-error detection (dec_dbl).
module hamming74_codec
  import hamming_pkg::*;
(
  input  logic [DATA_BITS-1:0] enc_data,
  output logic [CW_BITS-1:0]   enc_cw,
  input  logic [CW_BITS-1:0]   dec_cw,
  output logic [DATA_BITS-1:0] dec_data,
  output logic [SYN_BITS-1:0]  dec_syndrome,
`ifdef HAMMING_SECDED_EN
  output logic                 dec_dbl,
`endif
  output logic                 dec_err
);
  logic [SYN_BITS-1:0] syn;
  logic [6:0]          flip;
  logic [6:0]          fix_cw;
  logic                do_fix;

  always_comb begin
    enc_cw         = '0;
    enc_cw[POS_D1] = enc_data[0];
    enc_cw[POS_D2] = enc_data[1];
    enc_cw[POS_D3] = enc_data[2];
    enc_cw[POS_D4] = enc_data[3];
    enc_cw[POS_P1] = enc_data[0] ^ enc_data[1] ^ enc_data[3];
    enc_cw[POS_P2] = enc_data[0] ^ enc_data[2] ^ enc_data[3];
    enc_cw[POS_P4] = enc_data[1] ^ enc_data[2] ^ enc_data[3];
`ifdef HAMMING_SECDED_EN
    enc_cw[POS_PALL] = ^enc_cw[6:0];
`endif
  end

  always_comb begin
    syn[0] = dec_cw[POS_P1] ^ dec_cw[POS_D1] ^ dec_cw[POS_D2] ^ dec_cw[POS_D4];
    syn[1] = dec_cw[POS_P2] ^ dec_cw[POS_D1] ^ dec_cw[POS_D3] ^ dec_cw[POS_D4];
    syn[2] = dec_cw[POS_P4] ^ dec_cw[POS_D2] ^ dec_cw[POS_D3] ^ dec_cw[POS_D4];
`ifdef HAMMING_SECDED_EN
    // A passing overall parity with a non-zero syndrome means two flips: report, never correct.
    do_fix  = (^dec_cw) && (syn != '0);
    dec_err = ^dec_cw;
    dec_dbl = !(^dec_cw) && (syn != '0);
`else
    do_fix  = (syn != '0);
    dec_err = do_fix;
`endif
    for (int i = 0; i < 7; i++) begin
      flip[i] = do_fix && (syn == SYN_BITS'(i + 1));
    end
    fix_cw       = dec_cw[6:0] ^ flip;
    dec_data     = {fix_cw[POS_D4], fix_cw[POS_D3], fix_cw[POS_D2], fix_cw[POS_D1]};
    dec_syndrome = syn;
  end
endmodule

// File: rtl/hamming_link_ctrl.sv
// Serial Hamming link controller: nibble -> serial codeword on TX, framed serial -> corrected nibble on RX.
// Defining HAMMING_SECDED_EN selects 8-bit SECDED frames and adds the rx_dbl output.
// Handshake: a nibble transfers on a rising edge where tx_valid && tx_ready; tx_ready never depends on tx_valid.
module hamming_link_ctrl
  import hamming_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [3:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_frame,
  input  logic       serial_in,
  input  logic       rx_frame,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [2:0] rx_syndrome,
`ifdef HAMMING_SECDED_EN
  output logic       rx_dbl,
`endif
  output logic [1:0] dbg_tx_state,
  output logic [1:0] dbg_rx_state
);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(BIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] CW_LAST  = BIT_W'(CW_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 init_done_q, init_done_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_err_q, rx_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [SYN_BITS-1:0]  rx_syn_q, rx_syn_d;
  logic                 rx_dbl_q, rx_dbl_d;
  logic                 rx_step;

  logic [CW_BITS-1:0]   enc_cw;
  logic [DATA_BITS-1:0] dec_data;
  logic [SYN_BITS-1:0]  dec_syn;
  logic                 dec_err;
  logic                 dec_dbl;

  hamming74_codec u_codec (
    .enc_data     (tx_data),
    .enc_cw       (enc_cw),
    .dec_cw       (rx_sr_q),
    .dec_data     (dec_data),
    .dec_syndrome (dec_syn),
`ifdef HAMMING_SECDED_EN
    .dec_dbl      (dec_dbl),
`endif
    .dec_err      (dec_err)
  );
`ifndef HAMMING_SECDED_EN
  assign dec_dbl = 1'b0;
`endif

  // init_done_q keeps tx_ready low while rst is held, since the idle state is also the reset state.
  assign tx_ready   = init_done_q && (tx_state_q == TX_IDLE);
  assign tx_frame   = (tx_state_q == TX_SHIFT);
  assign serial_out = tx_frame && tx_sr_q[0];

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_sr_d     = tx_sr_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    init_done_d = 1'b1;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_sr_d    = enc_cw;
          tx_bit_d   = '0;
          tx_cnt_d   = '0;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_sr_d  = tx_sr_q >> 1;
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == CW_LAST) tx_state_d = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_GAP: begin
        if (tx_cnt_q == GAP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // The bit/cycle position keeps running through RX_DECODE so a frame that follows
  // with rx_frame still high is tracked without losing its first cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sr_d    = rx_sr_q;
    rx_bit_d   = rx_bit_q;
    rx_cnt_d   = rx_cnt_q;
    rx_valid_d = 1'b0;
    rx_err_d   = rx_err_q;
    rx_data_d  = rx_data_q;
    rx_syn_d   = rx_syn_q;
    rx_dbl_d   = rx_dbl_q;
    rx_step    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_frame) begin
          rx_step    = 1'b1;
          rx_state_d = RX_SAMPLE;
        end
      end
      RX_SAMPLE: begin
        if (rx_frame) rx_step = 1'b1;
        else          rx_state_d = RX_IDLE;
      end
      RX_DECODE: begin
        rx_valid_d = 1'b1;
        rx_data_d  = dec_data;
        rx_err_d   = dec_err;
        rx_syn_d   = dec_syn;
        rx_dbl_d   = dec_dbl;
        if (rx_frame) begin
          rx_step    = 1'b1;
          rx_state_d = RX_SAMPLE;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_step) begin
      if (rx_cnt_q == BIT_MID) begin
        rx_sr_d = {serial_in, rx_sr_q[CW_BITS-1:1]};
        if (rx_bit_q == CW_LAST) rx_state_d = RX_DECODE;
      end
      if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_bit_d = (rx_bit_q == CW_LAST) ? '0 : rx_bit_q + 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
    if (rx_state_d == RX_IDLE) begin
      rx_cnt_d = '0;
      rx_bit_d = '0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_sr_q     <= '0;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      init_done_q <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_sr_q     <= '0;
      rx_bit_q    <= '0;
      rx_cnt_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_syn_q    <= '0;
      rx_dbl_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_sr_q     <= tx_sr_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      init_done_q <= init_done_d;
      rx_state_q  <= rx_state_d;
      rx_sr_q     <= rx_sr_d;
      rx_bit_q    <= rx_bit_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      rx_data_q   <= rx_data_d;
      rx_syn_q    <= rx_syn_d;
      rx_dbl_q    <= rx_dbl_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_err       = rx_err_q;
  assign rx_data      = rx_data_q;
  assign rx_syndrome  = rx_syn_q;
`ifdef HAMMING_SECDED_EN
  assign rx_dbl       = rx_dbl_q;
`else
  logic unused_dbl;
  assign unused_dbl   = rx_dbl_q;
`endif
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;
endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Bench for hamming_link_ctrl: one instance at BIT_CYCLES=1 (loopback or driven RX), one at BIT_CYCLES=4 in loopback.
// Honours HAMMING_SECDED_EN for frame length and the rx_dbl port.
module tb_hamming_link_ctrl;
  import hamming_pkg::*;

  logic clk;
  logic rst;

  logic [3:0] tx_data1, rx_data1, tx_data4, rx_data4;
  logic       tx_valid1, tx_ready1, serial_out1, tx_frame1, serial_in1, rx_frame1;
  logic       rx_valid1, rx_err1, rx_dbl1;
  logic       tx_valid4, tx_ready4, serial_out4, tx_frame4;
  logic       rx_valid4, rx_err4, rx_dbl4;
  logic [2:0] rx_syn1, rx_syn4;
  logic [1:0] dbg_tx1, dbg_rx1, dbg_tx4, dbg_rx4;
  logic       lb1, sin_drv, rfr_drv;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [8:0] exp_q[$];   // {dbl, syndrome, err, data} for the BIT_CYCLES=1 instance
  logic [8:0] exp4_q[$];  // same, BIT_CYCLES=4 instance

  assign serial_in1 = lb1 ? serial_out1 : sin_drv;
  assign rx_frame1  = lb1 ? tx_frame1   : rfr_drv;

  hamming_link_ctrl #(.BIT_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk1(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .serial_out(serial_out1), .tx_frame(tx_frame1), .serial_in(serial_in1), .rx_frame(rx_frame1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_err(rx_err1), .rx_syndrome(rx_syn1),
`ifdef HAMMING_SECDED_EN
    .rx_dbl(rx_dbl1),
`endif
    .dbg_tx_state(dbg_tx1), .dbg_rx_state(dbg_rx1)
  );

  hamming_link_ctrl #(.BIT_CYCLES(4), .GAP_CYCLES(1)) dut4 (
    .clk1(clk), .rst(rst), .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
    .serial_out(serial_out4), .tx_frame(tx_frame4), .serial_in(serial_out4), .rx_frame(tx_frame4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_err(rx_err4), .rx_syndrome(rx_syn4),
`ifdef HAMMING_SECDED_EN
    .rx_dbl(rx_dbl4),
`endif
    .dbg_tx_state(dbg_tx4), .dbg_rx_state(dbg_rx4)
  );

`ifndef HAMMING_SECDED_EN
  assign rx_dbl1 = 1'b0;
  assign rx_dbl4 = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Codeword from the textbook equations; index i holds position i+1, bit 7 is overall parity.
  function automatic logic [7:0] model_cw(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic logic [7:0] flip(input logic [7:0] cw, input int pos);
    logic [7:0] c;
    c = cw;
    if (pos > 0) c[pos-1] = ~c[pos-1];
    return c;
  endfunction

  // Single flip at pos: data restored, syndrome names the position (0 for the parity bit 8).
  function automatic logic [8:0] exp_word(input logic [3:0] d, input int pos);
    logic [2:0] syn;
    syn = (pos >= 1 && pos <= 7) ? 3'(pos) : 3'd0;
    return {1'b0, syn, (pos != 0), d};
  endfunction

  always @(negedge clk) begin
    if (rx_valid1) begin
      if (exp_q.size() == 0) check("rx1_spurious", 1, 0);
      else check("rx1_word", {rx_dbl1, rx_syn1, rx_err1, rx_data1}, exp_q.pop_front());
    end
    if (rx_valid4) begin
      if (exp4_q.size() == 0) check("rx4_spurious", 1, 0);
      else check("rx4_word", {rx_dbl4, rx_syn4, rx_err4, rx_data4}, exp4_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge with dut1 idle; returns at a negedge with dut1 idle again.
  task automatic tx1(input logic [3:0] d);
    logic [7:0] cw;
    cw        = model_cw(d);
    tx_data1  = d;
    tx_valid1 = 1'b1;
    check("tx1_ready_pre", tx_ready1, 1);
    if (lb1) exp_q.push_back(exp_word(d, 0));
    @(negedge clk);
    tx_valid1 = 1'b0;
    tx_data1  = 4'($urandom);
    for (int i = 0; i < CW_BITS; i++) begin
      check("tx1_frame", tx_frame1, 1);
      check("tx1_bit", serial_out1, cw[i]);
      check("tx1_ready_busy", tx_ready1, 0);
      @(negedge clk);
    end
    check("tx1_gap_frame", tx_frame1, 0);
    check("tx1_gap_out", serial_out1, 0);
    check("tx1_gap_ready", tx_ready1, 0);
    @(negedge clk);
    check("tx1_ready_post", tx_ready1, 1);
  endtask

  task automatic rx_drive(input logic [7:0] cw, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rfr_drv = 1'b1;
      sin_drv = cw[i];
      @(negedge clk);
    end
  endtask

  task automatic rx_idle(input int n);
    rfr_drv = 1'b0;
    sin_drv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cw;
    logic [3:0] d;
    int pos;
    rst = 1'b1;
    tx_data1 = '0; tx_valid1 = 1'b0; tx_data4 = '0; tx_valid4 = 1'b0;
    lb1 = 1'b0; sin_drv = 1'b0; rfr_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", tx_ready1, 0);
    check("rst_tx_out", {tx_frame1, serial_out1, tx_frame4, serial_out4}, 0);
    check("rst_rx1", {rx_valid1, rx_err1, rx_dbl1, rx_syn1, rx_data1}, 0);
    check("rst_rx4", {rx_valid4, rx_err4, rx_dbl4, rx_syn4, rx_data4}, 0);
    check("rst_dbg", {dbg_tx1, dbg_rx1, dbg_tx4, dbg_rx4}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready1, 1);

    // Loopback: TX serialisation plus clean RX decode.
    lb1 = 1'b1;
    tx1(4'b1011);
    for (int k = 0; k < 4; k++) tx1(4'($urandom));
    lb1 = 1'b0;
    rx_idle(3);

    // Driven RX: every single-bit error position, including none.
    for (int p = 0; p <= CW_BITS; p++) begin
      exp_q.push_back(exp_word(4'b1011, p));
      rx_drive(flip(model_cw(4'b1011), p), CW_BITS);
      rx_idle(2);
    end

    // Aborted frame, then a clean all-zero frame.
    rx_drive(model_cw(4'b0110), 4);
    rx_idle(3);
    exp_q.push_back(exp_word(4'b0000, 0));
    rx_drive(model_cw(4'b0000), CW_BITS);
    rx_idle(3);

    // Back-to-back frames with rx_frame held high throughout.
    for (int k = 0; k < 5; k++) begin
      d   = 4'($urandom);
      pos = $urandom_range(0, 7);
      exp_q.push_back(exp_word(d, pos));
      rx_drive(flip(model_cw(d), pos), CW_BITS);
    end
    rx_idle(3);

`ifdef HAMMING_SECDED_EN
    // Two parity-bit flips: detected, not corrected.
    exp_q.push_back({1'b1, 3'd3, 1'b0, 4'b1011});
    rx_drive(flip(flip(model_cw(4'b1011), 1), 2), CW_BITS);
    rx_idle(3);
`endif

    // Reset in the middle of a TX frame.
    tx_data1  = 4'b1111;
    tx_valid1 = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_frame", tx_frame1, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_frame", tx_frame1, 0);
    check("rst_mid_out", serial_out1, 0);
    check("rst_mid_ready", tx_ready1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_post", tx_ready1, 1);

    // BIT_CYCLES=4, back-to-back tx_valid for 4'hF then 4'h0.
    tx_data4  = 4'hF;
    tx_valid4 = 1'b1;
    exp4_q.push_back(exp_word(4'hF, 0));
    @(negedge clk);
    tx_data4 = 4'h0;
    exp4_q.push_back(exp_word(4'h0, 0));
    cw = model_cw(4'hF);
    for (int i = 0; i < CW_BITS * 4; i++) begin
      check("b2b_f_frame", tx_frame4, 1);
      check("b2b_f_bit", serial_out4, cw[i / 4]);
      @(negedge clk);
    end
    check("b2b_gap", {tx_frame4, tx_ready4}, 2'b00);
    @(negedge clk);
    check("b2b_idle", {tx_frame4, tx_ready4}, 2'b01);
    @(negedge clk);
    tx_valid4 = 1'b0;
    cw = model_cw(4'h0);
    for (int i = 0; i < CW_BITS * 4; i++) begin
      check("b2b_0_frame", tx_frame4, 1);
      check("b2b_0_bit", serial_out4, cw[i / 4]);
      @(negedge clk);
    end
    check("b2b_end", tx_frame4, 0);

    repeat (20) @(negedge clk);
    check("sb1_left", exp_q.size(), 0);
    check("sb4_left", exp4_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
